// File: rtl/pong_pkg.sv
// Shared types and constants for the pong button conditioning path.
package pong_pkg;

  localparam int unsigned DbCyclesDefault = 2_000_000;  // 20 ms at 100 MHz

  localparam logic [1:0] StateZero  = 2'b00;
  localparam logic [1:0] StateWait1 = 2'b01;
  localparam logic [1:0] StateWait0 = 2'b10;
  localparam logic [1:0] StateOne   = 2'b11;

  typedef enum logic [1:0] {
    StZero  = StateZero,
    StWait1 = StateWait1,
    StWait0 = StateWait0,
    StOne   = StateOne
  } db_state_e;

  // Counter must hold DB_CYCLES-1; never narrower than one bit.
  function automatic int unsigned db_cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/pong_btn_conditioner_if.sv
// Raw pushbutton inputs and their debounced levels/ticks for both players.
interface pong_btn_conditioner_if;

  logic [1:0] btn1;
  logic [1:0] btn2;
  logic [1:0] btn1_db;
  logic [1:0] btn2_db;
  logic [1:0] btn1_tick;
  logic [1:0] btn2_tick;
  logic       any_tick;

  modport master (
    output btn1, btn2,
    input  btn1_db, btn2_db, btn1_tick, btn2_tick, any_tick
  );

  modport slave (
    input  btn1, btn2,
    output btn1_db, btn2_db, btn1_tick, btn2_tick, any_tick
  );

endinterface

// File: rtl/pong_debounce_bit.sv
// One button channel: 2-flop synchronizer, debounce FSM with stability counter,
// registered debounced level and rising-edge tick.
module pong_debounce_bit
  import pong_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DbCyclesDefault
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic db_o,
  output logic tick_o
);

  localparam int unsigned    CntW    = db_cnt_width(DB_CYCLES);
  localparam logic [CntW-1:0] CntLoad = CntW'(DB_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [1:0]      sync_q;
  logic            btn_s;
  db_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic            db_q;
  logic            tick_q;

  assign btn_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b00;
      state_q <= StZero;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      // btn_i is asynchronous; only sync_q[1] may feed the FSM.
      sync_q <= {sync_q[0], btn_i};
      tick_q <= 1'b0;
      unique case (state_q)
        StZero: begin
          if (btn_s) begin
            state_q <= StWait1;
            cnt_q   <= CntLoad;
          end
        end
        StWait1: begin
          if (!btn_s) begin
            state_q <= StZero;
          end else if (cnt_q == '0) begin
            state_q <= StOne;
            db_q    <= 1'b1;
            tick_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        StOne: begin
          if (!btn_s) begin
            state_q <= StWait0;
            cnt_q   <= CntLoad;
          end
        end
        StWait0: begin
          if (btn_s) begin
            state_q <= StOne;
          end else if (cnt_q == '0) begin
            state_q <= StZero;
            db_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        default: begin
          state_q <= StZero;
          db_q    <= 1'b0;
        end
      endcase
    end
  end

  assign db_o   = db_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/pong_btn_conditioner.sv
// Debounces both players' up/down buttons; four identical channels plus a
// combined tick used as the game-start trigger.
module pong_btn_conditioner
  import pong_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DbCyclesDefault
) (
  input logic                  clk,
  input logic                  reset,
  pong_btn_conditioner_if.slave bus
);

  // Channel order: {btn2[1], btn2[0], btn1[1], btn1[0]}.
  logic [3:0] raw;
  logic [3:0] db;
  logic [3:0] tick;

  assign raw = {bus.btn2, bus.btn1};

  for (genvar i = 0; i < 4; i++) begin : g_chan
    pong_debounce_bit #(
      .DB_CYCLES(DB_CYCLES)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .btn_i (raw[i]),
      .db_o  (db[i]),
      .tick_o(tick[i])
    );
  end

  assign bus.btn1_db   = db[1:0];
  assign bus.btn2_db   = db[3:2];
  assign bus.btn1_tick = tick[1:0];
  assign bus.btn2_tick = tick[3:2];
  assign bus.any_tick  = |tick;

endmodule

// File: tb/tb_pong_btn_conditioner.sv
// Randomized and directed bench for pong_btn_conditioner with DB_CYCLES=4,
// checked against a run-length reference model of the debounce rules.
module tb_pong_btn_conditioner;

  localparam int unsigned DB = 4;

  logic clk = 1'b0;
  logic reset;

  pong_btn_conditioner_if bus ();

  pong_btn_conditioner #(
    .DB_CYCLES(DB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a debounced level flips once the raw input, seen two
  // samples late, has disagreed with it for DB+1 consecutive samples.
  logic [3:0] hist[$];
  int         run[4];
  logic [3:0] m_db;
  logic [3:0] m_tick;

  task automatic model_edge(input logic [3:0] raw, input logic rst);
    logic [3:0] late;
    if (rst) begin
      hist.delete();
      m_db   = '0;
      m_tick = '0;
      for (int i = 0; i < 4; i++) run[i] = 0;
    end else begin
      late = (hist.size() >= 2) ? hist[hist.size()-2] : 4'b0000;
      hist.push_back(raw);
      while (hist.size() > 2) void'(hist.pop_front());
      m_tick = '0;
      for (int i = 0; i < 4; i++) begin
        if (late[i] != m_db[i]) begin
          run[i]++;
          if (run[i] == int'(DB) + 1) begin
            m_db[i]   = ~m_db[i];
            m_tick[i] = m_db[i];
            run[i]    = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
    end
  endtask

  // One clock: drive, advance model, sample #1 after the edge and compare.
  task automatic step(input logic [1:0] b1, input logic [1:0] b2, input logic rst);
    bus.btn1 = b1;
    bus.btn2 = b2;
    reset    = rst;
    @(posedge clk);
    model_edge({b2, b1}, rst);
    #1;
    check_eq("btn1_db",   32'(bus.btn1_db),   32'(m_db[1:0]));
    check_eq("btn2_db",   32'(bus.btn2_db),   32'(m_db[3:2]));
    check_eq("btn1_tick", 32'(bus.btn1_tick), 32'(m_tick[1:0]));
    check_eq("btn2_tick", 32'(bus.btn2_tick), 32'(m_tick[3:2]));
    check_eq("any_tick",  32'(bus.any_tick),  32'(|m_tick));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 2'b00, 1'b0);
  endtask

  initial begin
    int ticks;
    int anys;
    int bad;
    logic [1:0] b1;
    logic [1:0] b2;
    int hold[4];

    bus.btn1 = '0;
    bus.btn2 = '0;
    reset    = 1'b1;
    step(2'b00, 2'b00, 1'b1);
    step(2'b00, 2'b00, 1'b1);
    check_eq("reset_outs", 32'({bus.btn2_db, bus.btn1_db, bus.btn2_tick, bus.btn1_tick,
                                bus.any_tick}), 32'd0);
    idle(4);

    // Clean press on btn1[1]; step index i leaves us just after edge i.
    ticks = 0; anys = 0;
    for (int i = 0; i < 20; i++) begin
      step(2'b10, 2'b00, 1'b0);
      if (i == 5) check_eq("press_db_e5", 32'(bus.btn1_db[1]), 32'd0);
      if (i == 6) check_eq("press_db_e6", 32'(bus.btn1_db[1]), 32'd1);
      ticks += int'(bus.btn1_tick[1]);
      anys  += int'(bus.any_tick);
    end
    check_eq("press_ticks", 32'(ticks), 32'd1);
    check_eq("press_any", 32'(anys), 32'd1);
    idle(12);
    check_eq("release_db", 32'(bus.btn1_db[1]), 32'd0);

    // Bounce on btn2[0].
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      b2 = (i < 8 && (i % 4) < 2) ? 2'b01 : 2'b00;
      step(2'b00, b2, 1'b0);
      bad += int'(bus.btn2_db[0] | bus.btn2_tick[0]);
    end
    check_eq("bounce_quiet", 32'(bad), 32'd0);

    // Release glitch on held btn1[0].
    ticks = 0; bad = 0;
    for (int i = 0; i < 30; i++) begin
      b1 = (i >= 12 && i < 14) ? 2'b00 : 2'b01;
      step(b1, 2'b00, 1'b0);
      ticks += int'(bus.btn1_tick[0]);
      if (i >= 6) bad += int'(!bus.btn1_db[0]);
    end
    check_eq("glitch_ticks", 32'(ticks), 32'd1);
    check_eq("glitch_db_drop", 32'(bad), 32'd0);
    idle(12);

    // Simultaneous presses.
    anys = 0;
    for (int i = 0; i < 14; i++) begin
      step(2'b11, 2'b10, 1'b0);
      if (i == 6)
        check_eq("simul_ticks", 32'({bus.btn2_tick, bus.btn1_tick}), 32'b1011);
      anys += int'(bus.any_tick);
    end
    check_eq("simul_any", 32'(anys), 32'd1);
    idle(12);

    // Reset in the middle of a pending btn2[1] press.
    for (int i = 0; i < 4; i++) step(2'b00, 2'b10, 1'b0);
    step(2'b00, 2'b10, 1'b1);
    check_eq("midrst_outs", 32'({bus.btn2_db, bus.btn1_db, bus.btn2_tick, bus.btn1_tick,
                                 bus.any_tick}), 32'd0);
    for (int j = 0; j < 12; j++) begin
      step(2'b00, 2'b10, 1'b0);
      if (j == 5) check_eq("midrst_tick_early", 32'(bus.btn2_tick), 32'd0);
      if (j == 6) check_eq("midrst_tick", 32'(bus.btn2_tick), 32'b10);
    end
    idle(12);

    // Long hold: no auto-repeat.
    ticks = 0; bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step(2'b10, 2'b00, 1'b0);
      ticks += int'(bus.btn1_tick[1]);
      if (i >= 6) bad += int'(!bus.btn1_db[1]);
    end
    check_eq("hold_ticks", 32'(ticks), 32'd1);
    check_eq("hold_db_drop", 32'(bad), 32'd0);
    idle(12);

    // Random bursts: each bit keeps its level for 1..10 cycles, rare resets.
    b1 = '0; b2 = '0;
    for (int i = 0; i < 4; i++) hold[i] = 0;
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          hold[i] = int'($urandom_range(1, 10));
          if (i < 2) b1[i] = 1'($urandom);
          else       b2[i-2] = 1'($urandom);
        end
        hold[i]--;
      end
      step(b1, b2, ($urandom_range(0, 299) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pong_btn_conditioner.md
PONG_BTN_CONDITIONER -- requirements
Module: pong_btn_conditioner

Interface
REQ-001 Parameter DB_CYCLES, default 2_000_000, debounce stability window in clk cycles (20 ms at 100 MHz); legal range 2..2^24-1.
REQ-002 clk  input  1  system clock; single clock domain for the whole block.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 btn1  input  2  raw asynchronous pushbuttons, player 1 (bit1 up, bit0 down).
REQ-005 btn2  input  2  raw asynchronous pushbuttons, player 2 (bit1 up, bit0 down).
REQ-006 btn1_db  output  2  debounced level, player 1; feeds pong_graph and the game FSM.
REQ-007 btn2_db  output  2  debounced level, player 2.
REQ-008 btn1_tick  output  2  one-cycle pulse per bit on each debounced 0->1 transition.
REQ-009 btn2_tick  output  2  one-cycle pulse per bit on each debounced 0->1 transition.
REQ-010 any_tick  output  1  OR of all four tick bits; game-start trigger.

Function
REQ-011 Each of the 4 button bits SHALL be handled by an independent, identical channel.
REQ-012 Each channel SHALL pass its raw input through a 2-flop synchronizer before any other logic.
REQ-013 Each channel FSM SHALL have states ZERO, WAIT1, ONE, WAIT0 and a counter of width clog2(DB_CYCLES).
REQ-014 ZERO: sync=1 -> WAIT1, counter loaded with DB_CYCLES-1; otherwise stay.
REQ-015 WAIT1: sync=0 -> ZERO (bounce rejected); sync=1 and counter=0 -> ONE; otherwise decrement.
REQ-016 ONE: sync=0 -> WAIT0, counter loaded with DB_CYCLES-1; otherwise stay.
REQ-017 WAIT0: sync=1 -> ONE; sync=0 and counter=0 -> ZERO; otherwise decrement.
REQ-018 db output SHALL be registered, 1 in states ONE and WAIT0 and 0 in ZERO and WAIT1.
REQ-019 tick SHALL be registered and high for exactly the one cycle in which db first reads 1 after the WAIT1->ONE transition.
REQ-020 Latency: raw input stable from clock edge 0 SHALL produce db=1 and tick=1 after edge DB_CYCLES+2; release latency SHALL be identical, with no tick.
REQ-021 A bounce shorter than DB_CYCLES consecutive synchronized cycles SHALL produce no change on db and no tick.
REQ-022 Simultaneous presses on several bits SHALL produce simultaneous ticks; any_tick SHALL stay one cycle wide.
REQ-023 A held button SHALL produce exactly one tick; there is no auto-repeat.
REQ-024 The counter SHALL never wrap; it holds at 0 only transiently in the cycle a WAIT state is left.

Reset
REQ-025 On reset=1 at a clock edge, all channels SHALL enter ZERO, counters SHALL clear, and synchronizer flops, db, tick and any_tick SHALL read 0 the following cycle.
REQ-026 Reset asserted mid-WAIT1 SHALL abort the pending press; a button still held after reset SHALL tick again only after a full DB_CYCLES+2 window.

Structure
REQ-027 State encoding (ZERO, WAIT1, WAIT0, ONE as 2-bit localparams) and the default DB_CYCLES SHALL live in a shared package, pong_pkg.
REQ-028 One sub-module, pong_debounce_bit (synchronizer, FSM, counter, db/tick registers), SHALL be instantiated four times; the top level only wires channels and forms any_tick.

Verification (DB_CYCLES=4 in simulation)
REQ-029 Clean press: btn1[1] 0->1 held 20 cycles -> btn1_db[1]=1 after edge 6; btn1_tick[1] and any_tick high for exactly 1 cycle.
REQ-030 Bounce: btn2[0] toggles 1,0,1,0 every 2 cycles, then stays 0 -> btn2_db and btn2_tick remain 0 throughout.
REQ-031 Release glitch: btn1[0] held, then 0 for 2 cycles, then 1 again -> btn1_db[0] stays 1 and no second tick occurs.
REQ-032 Simultaneous: btn1=2'b11 and btn2=2'b10 rise on the same edge -> 3 tick bits high in the same cycle; any_tick is a single 1-cycle pulse.
REQ-033 Reset mid-operation: press btn2[1], assert reset at edge 4 for 1 cycle, keep the button held -> all outputs 0 at edge 5; tick fires DB_CYCLES+2 edges after reset deasserts.
REQ-034 Long hold: btn1[1] held 1000 cycles -> exactly one tick, btn1_db[1] constant 1 from edge 6 onward.
